// File: rtl/store_commit_buffer.sv
// ============================================================================
// Module   : store_commit_buffer
// Purpose  : In-order buffer of retired stores, drained one at a time to D-memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_commit_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            retire_store_valid,
    output logic                            retire_store_ready,
    input  logic [ADDR_WIDTH-1:0]           retire_store_addr,
    input  logic [DATA_WIDTH-1:0]           retire_store_data,
    input  logic [DATA_WIDTH/8-1:0]         retire_store_mask,
    output logic                            mem_wr_valid,
    input  logic                            mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]           mem_wr_addr,
    output logic [DATA_WIDTH-1:0]           mem_wr_data,
    output logic [DATA_WIDTH/8-1:0]         mem_wr_mask,
    input  logic                            mem_wr_ack,
    input  logic [ADDR_WIDTH-1:0]           ld_check_addr,
    output logic                            ld_conflict,
    input  logic                            drain_req,
    output logic                            drain_done,
    output logic [$clog2(FIFO_DEPTH):0]     sb_count
);

    localparam int c_mask_width = DATA_WIDTH / 8;
    localparam int c_ptr_width  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_width  = c_ptr_width + 1;
    localparam logic [c_cnt_width-1:0] c_depth = c_cnt_width'(FIFO_DEPTH);
    localparam logic [c_cnt_width-1:0] c_one   = c_cnt_width'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    logic [ADDR_WIDTH-1:0]   r_addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   r_data_mem [FIFO_DEPTH];
    logic [c_mask_width-1:0] r_mask_mem [FIFO_DEPTH];

    logic [c_ptr_width-1:0]  r_head;
    logic [c_ptr_width-1:0]  r_tail;
    logic [c_cnt_width-1:0]  r_count;
    logic [c_cnt_width-1:0]  w_count_nxt;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_drain_pend;
    logic                    r_drain_done;
    logic                    w_drain_any;
    logic                    w_enq;
    logic                    w_deq;
    logic                    w_conflict;
    logic [FIFO_DEPTH-1:0]   w_entry_valid;
    logic                    w_unused_ld_bits;

    // Ready is forced low while reset is asserted so every output reads zero in reset.
    assign retire_store_ready = rst_n && (r_count < c_depth);
    assign w_enq              = retire_store_valid && retire_store_ready;

    // ------------------------------------------------------------------
    // Entry storage (data path, no reset needed: validity comes from count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr_mem[r_tail] <= retire_store_addr;
            r_data_mem[r_tail] <= retire_store_data;
            r_mask_mem[r_tail] <= retire_store_mask;
        end
    end

    // ------------------------------------------------------------------
    // Write-port FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_deq       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_wr_ready) begin
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (mem_wr_ack) begin
                    w_deq       = 1'b1;
                    w_state_nxt = (r_count != c_one) ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem_wr_valid = (r_state == ST_REQ);
    assign mem_wr_addr  = mem_wr_valid ? r_addr_mem[r_head] : '0;
    assign mem_wr_data  = mem_wr_valid ? r_data_mem[r_head] : '0;
    assign mem_wr_mask  = mem_wr_valid ? r_mask_mem[r_head] : '0;

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    assign sb_count = r_count;

    // ------------------------------------------------------------------
    // Fence drain handshake: fires when the buffer is about to be empty
    // ------------------------------------------------------------------
    assign w_drain_any = r_drain_pend | drain_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drain_pend <= 1'b0;
            r_drain_done <= 1'b0;
        end else begin
            r_drain_done <= w_drain_any && (w_count_nxt == '0);
            r_drain_pend <= w_drain_any && (w_count_nxt != '0);
        end
    end

    assign drain_done = r_drain_done;

    // ------------------------------------------------------------------
    // Load conflict check (word granularity), buffered entries plus enqueue
    // ------------------------------------------------------------------
    always_comb begin
        w_entry_valid = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_entry_valid[i] =
                ({1'b0, c_ptr_width'(c_ptr_width'(i) - r_head)} < r_count);
        end
    end

    always_comb begin
        w_conflict = w_enq && (|retire_store_mask) &&
                     (retire_store_addr[ADDR_WIDTH-1:2] == ld_check_addr[ADDR_WIDTH-1:2]);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_entry_valid[i] && (|r_mask_mem[i]) &&
                (r_addr_mem[i][ADDR_WIDTH-1:2] == ld_check_addr[ADDR_WIDTH-1:2])) begin
                w_conflict = 1'b1;
            end
        end
    end

    assign ld_conflict      = w_conflict;
    assign w_unused_ld_bits = &{1'b0, ld_check_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_store_commit_buffer.sv
// ============================================================================
// Module   : tb_store_commit_buffer
// Purpose  : Directed self-checking bench for store_commit_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_commit_buffer;

    logic        clk;
    logic        rst_n;
    logic        retire_store_valid;
    logic        retire_store_ready;
    logic [31:0] retire_store_addr;
    logic [31:0] retire_store_data;
    logic [3:0]  retire_store_mask;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_mask;
    logic        mem_wr_ack;
    logic [31:0] ld_check_addr;
    logic        ld_conflict;
    logic        drain_req;
    logic        drain_done;
    logic [4:0]  sb_count;

    int n_tests = 0;
    int n_fail  = 0;

    store_commit_buffer #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .retire_store_valid (retire_store_valid),
        .retire_store_ready (retire_store_ready),
        .retire_store_addr  (retire_store_addr),
        .retire_store_data  (retire_store_data),
        .retire_store_mask  (retire_store_mask),
        .mem_wr_valid       (mem_wr_valid),
        .mem_wr_ready       (mem_wr_ready),
        .mem_wr_addr        (mem_wr_addr),
        .mem_wr_data        (mem_wr_data),
        .mem_wr_mask        (mem_wr_mask),
        .mem_wr_ack         (mem_wr_ack),
        .ld_check_addr      (ld_check_addr),
        .ld_conflict        (ld_conflict),
        .drain_req          (drain_req),
        .drain_done         (drain_done),
        .sb_count           (sb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (mem_wr_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("wait_valid", {63'd0, mem_wr_valid}, 64'd1);
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        retire_store_valid = 1'b1;
        retire_store_addr  = a;
        retire_store_data  = d;
        retire_store_mask  = m;
    endtask

    task automatic issue_and_ack();
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
        mem_wr_ack   = 1'b1;
        tick();
        mem_wr_ack   = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        retire_store_valid = 1'b0;
        retire_store_addr  = '0;
        retire_store_data  = '0;
        retire_store_mask  = '0;
        mem_wr_ready       = 1'b0;
        mem_wr_ack         = 1'b0;
        ld_check_addr      = '0;
        drain_req          = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_valid", {63'd0, mem_wr_valid}, 64'd0);
        chk("rst_count", {59'd0, sb_count}, 64'd0);
        chk("rst_done",  {63'd0, drain_done}, 64'd0);
        chk("rst_ready", {63'd0, retire_store_ready}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", {63'd0, retire_store_ready}, 64'd1);

        // Single store: valid rises two cycles after the enqueue cycle
        put(32'h100, 32'hDEADBEEF, 4'hF);
        tick();
        retire_store_valid = 1'b0;
        chk("single_count1", {59'd0, sb_count}, 64'd1);
        chk("single_valid_early", {63'd0, mem_wr_valid}, 64'd0);
        tick();
        chk("single_valid", {63'd0, mem_wr_valid}, 64'd1);
        chk("single_addr", {32'd0, mem_wr_addr}, 64'h100);
        chk("single_data", {32'd0, mem_wr_data}, 64'hDEADBEEF);
        chk("single_mask", {60'd0, mem_wr_mask}, 64'hF);
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
        chk("single_wait_valid", {63'd0, mem_wr_valid}, 64'd0);
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        chk("single_count0", {59'd0, sb_count}, 64'd0);
        tick();
        chk("single_idle", {63'd0, mem_wr_valid}, 64'd0);

        // Fill to 16 with the memory stalled
        for (int i = 0; i < 16; i++) begin
            put(32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF);
            tick();
        end
        chk("full_count", {59'd0, sb_count}, 64'd16);
        chk("full_ready", {63'd0, retire_store_ready}, 64'd0);
        put(32'hBAD0, 32'hBAD, 4'hF);
        tick();
        retire_store_valid = 1'b0;
        chk("full_reject", {59'd0, sb_count}, 64'd16);

        // Request held stable while ready is low
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {63'd0, mem_wr_valid}, 64'd1);
            chk("hold_addr", {32'd0, mem_wr_addr}, 64'h1000);
            chk("hold_data", {32'd0, mem_wr_data}, 64'hA0000000);
            chk("hold_mask", {60'd0, mem_wr_mask}, 64'hF);
            tick();
        end

        for (int i = 0; i < 16; i++) begin
            wait_valid();
            chk("fill_addr", {32'd0, mem_wr_addr}, {32'd0, 32'h1000 + 32'(4 * i)});
            chk("fill_data", {32'd0, mem_wr_data}, {32'd0, 32'hA0000000 + 32'(i)});
            mem_wr_ready = 1'b1;
            tick();
            mem_wr_ready = 1'b0;
            chk("no_double_issue", {63'd0, mem_wr_valid}, 64'd0);
            mem_wr_ack = 1'b1;
            tick();
            mem_wr_ack = 1'b0;
        end
        chk("fill_empty", {59'd0, sb_count}, 64'd0);

        // Steady state at count 3 with enqueue+ack together; 40 stores wrap pointers
        for (int i = 0; i < 3; i++) begin
            put(32'h2000 + 32'(4 * i), {16'hC0DE, 16'(i)}, 4'hF);
            tick();
        end
        retire_store_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            wait_valid();
            chk("wrap_addr", {32'd0, mem_wr_addr}, {32'd0, 32'h2000 + 32'(4 * k)});
            chk("wrap_data", {32'd0, mem_wr_data}, {32'd0, 16'hC0DE, 16'(k)});
            mem_wr_ready = 1'b1;
            tick();
            mem_wr_ready = 1'b0;
            mem_wr_ack   = 1'b1;
            if (k + 3 < 40) begin
                put(32'h2000 + 32'(4 * (k + 3)), {16'hC0DE, 16'(k + 3)}, 4'hF);
            end
            tick();
            mem_wr_ack         = 1'b0;
            retire_store_valid = 1'b0;
            chk("wrap_count", {59'd0, sb_count}, (k + 3 < 40) ? 64'd3 : 64'(39 - k));
        end

        // Load conflict
        put(32'h204, 32'h55, 4'h1);
        ld_check_addr = 32'h206;
        #1;
        chk("conf_enq", {63'd0, ld_conflict}, 64'd1);
        tick();
        retire_store_valid = 1'b0;
        #1;
        chk("conf_buf", {63'd0, ld_conflict}, 64'd1);
        ld_check_addr = 32'h208;
        #1;
        chk("conf_other_word", {63'd0, ld_conflict}, 64'd0);
        ld_check_addr = 32'h206;
        wait_valid();
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
        chk("conf_inflight", {63'd0, ld_conflict}, 64'd1);
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        #1;
        chk("conf_after_ack", {63'd0, ld_conflict}, 64'd0);

        // Drain with two entries; second request absorbed
        put(32'h300, 32'h1, 4'hF);
        tick();
        put(32'h304, 32'h2, 4'hF);
        tick();
        retire_store_valid = 1'b0;
        drain_req = 1'b1;
        tick();
        tick();
        drain_req = 1'b0;
        chk("drain_pend", {63'd0, drain_done}, 64'd0);
        wait_valid();
        issue_and_ack();
        chk("drain_mid", {63'd0, drain_done}, 64'd0);
        chk("drain_mid_count", {59'd0, sb_count}, 64'd1);
        wait_valid();
        issue_and_ack();
        chk("drain_pulse", {63'd0, drain_done}, 64'd1);
        tick();
        chk("drain_single", {63'd0, drain_done}, 64'd0);
        tick();
        chk("drain_quiet", {63'd0, drain_done}, 64'd0);

        // Drain while empty
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        chk("drain_empty_pulse", {63'd0, drain_done}, 64'd1);
        tick();
        chk("drain_empty_end", {63'd0, drain_done}, 64'd0);

        // Reset while waiting for an ack
        put(32'h400, 32'h77, 4'hF);
        tick();
        retire_store_valid = 1'b0;
        wait_valid();
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready  = 1'b0;
        ld_check_addr = 32'h400;
        rst_n         = 1'b0;
        tick();
        chk("mrst_valid", {63'd0, mem_wr_valid}, 64'd0);
        chk("mrst_addr", {32'd0, mem_wr_addr}, 64'd0);
        chk("mrst_data", {32'd0, mem_wr_data}, 64'd0);
        chk("mrst_count", {59'd0, sb_count}, 64'd0);
        chk("mrst_conflict", {63'd0, ld_conflict}, 64'd0);
        chk("mrst_ready", {63'd0, retire_store_ready}, 64'd0);
        rst_n      = 1'b1;
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        chk("mrst_ack_ignored", {59'd0, sb_count}, 64'd0);
        tick();
        tick();
        chk("mrst_idle", {63'd0, mem_wr_valid}, 64'd0);
        chk("mrst_ready_back", {63'd0, retire_store_ready}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
